alu_reg_sequencer: RTL



---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_decode.sv | 32 +++
 rtl/alu_reg_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU/register-file sequencer.
// Holds instruction class codes, instruction field bit positions, the FSM state
// encoding and the datapath mux/opcode defaults used by the decoder and the top.
package alu_seq_pkg;

  // Instruction class, bits [31:30]
  typedef enum logic [1:0] {
    CLS_LDI = 2'b00,
    CLS_ALU = 2'b01,
    CLS_RD  = 2'b10,
    CLS_NOP = 2'b11
  } cls_e;

  // Field bit positions; imm overlaps the low part of op (LDI only)
  localparam int CLS_MSB  = 31;
  localparam int CLS_LSB  = 30;
  localparam int DEST_MSB = 29;
  localparam int DEST_LSB = 26;
  localparam int ADRA_MSB = 25;
  localparam int ADRA_LSB = 22;
  localparam int ADRB_MSB = 21;
  localparam int ADRB_LSB = 18;
  localparam int OP_MSB   = 17;
  localparam int OP_LSB   = 10;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  // Must match the datapath's write-source mux and ALU opcode decode
  localparam logic [1:0] IMM_SEL_DEF   = 2'b00;
  localparam logic [1:0] ALU_SEL_DEF   = 2'b01;
  localparam logic [7:0] OP_PASS_A_DEF = 8'h00;

endpackage

// File: rtl/alu_seq_decode.sv
// Purpose : combinational field extraction and class flags for one micro-instruction.
// Latency : none (pure combinational); no backpressure, the caller selects the source word.
// Ports   : instr (32b) in; dest/adr_a/adr_b (4b), op (8b), imm (16b), is_ldi/is_alu/is_rd out.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  dest,
  output logic [3:0]  adr_a,
  output logic [3:0]  adr_b,
  output logic [7:0]  op,
  output logic [15:0] imm,
  output logic        is_ldi,
  output logic        is_alu,
  output logic        is_rd
);

  cls_e cls;

  always_comb begin
    cls    = cls_e'(instr[CLS_MSB:CLS_LSB]);
    dest   = instr[DEST_MSB:DEST_LSB];
    adr_a  = instr[ADRA_MSB:ADRA_LSB];
    adr_b  = instr[ADRB_MSB:ADRB_LSB];
    op     = instr[OP_MSB:OP_LSB];
    imm    = instr[IMM_MSB:IMM_LSB];
    is_ldi = (cls == CLS_LDI);
    is_alu = (cls == CLS_ALU);
    is_rd  = (cls == CLS_RD);
  end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Purpose : sequences micro-instructions into ALU/register-file datapath controls, handles result/write-back.
// Latency : LDI 2, ALU 3+N, RD 2+N cycles accept-to-ready (N = cycles waiting for datapath valid_o).
// Backpressure: instr_ready_o is high only in IDLE; a stalled datapath is bounded by TIMEOUT, which sets sticky err_o.
// Ports   : clk, a_reset_l (sync, active-low); instr_i/instr_valid_i/instr_ready_o host side;
//           data_in, mux_sel, seg_reg, adr_reg_a, adr_reg_b, op_in, we, valid_o, data_o datapath side;
//           result_o/result_valid_o read-data return; err_o timeout flag.
module alu_reg_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         TIMEOUT   = 16,
  parameter logic [1:0] IMM_SEL   = IMM_SEL_DEF,
  parameter logic [1:0] ALU_SEL   = ALU_SEL_DEF,
  parameter logic [7:0] OP_PASS_A = OP_PASS_A_DEF
) (
  input  logic        clk,
  input  logic        a_reset_l,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic [15:0] data_in,
  output logic [1:0]  mux_sel,
  output logic [3:0]  seg_reg,
  output logic [3:0]  adr_reg_a,
  output logic [3:0]  adr_reg_b,
  output logic [7:0]  op_in,
  output logic        we,
  input  logic        valid_o,
  input  logic [15:0] data_o,
  output logic [15:0] result_o,
  output logic        result_valid_o,
  output logic        err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]  data_in_q, data_in_d;
  logic [1:0]   mux_sel_q, mux_sel_d;
  logic [3:0]   seg_reg_q, seg_reg_d;
  logic [3:0]   adr_a_q, adr_a_d;
  logic [3:0]   adr_b_q, adr_b_d;
  logic [7:0]   op_q, op_d;
  logic         we_q, we_d;
  logic [15:0]  result_q, result_d;
  logic         result_vld_q, result_vld_d;
  logic         err_q, err_d;

  // Outputs are registered, so the decode that drives the ISSUE cycle must act
  // on the incoming word at the accept edge; afterwards the latched copy is used.
  logic [31:0] dec_src;
  logic [3:0]  dec_dest, dec_adr_a, dec_adr_b;
  logic [7:0]  dec_op;
  logic [15:0] dec_imm;
  logic        dec_ldi, dec_alu, dec_rd;

  assign dec_src = (state_q == ST_IDLE) ? instr_i : instr_q;

  alu_seq_decode u_decode (
    .instr  (dec_src),
    .dest   (dec_dest),
    .adr_a  (dec_adr_a),
    .adr_b  (dec_adr_b),
    .op     (dec_op),
    .imm    (dec_imm),
    .is_ldi (dec_ldi),
    .is_alu (dec_alu),
    .is_rd  (dec_rd)
  );

  assign instr_ready_o  = (state_q == ST_IDLE) && a_reset_l;
  assign data_in        = data_in_q;
  assign mux_sel        = mux_sel_q;
  assign seg_reg        = seg_reg_q;
  assign adr_reg_a      = adr_a_q;
  assign adr_reg_b      = adr_b_q;
  assign op_in          = op_q;
  // Gate with reset so a WB/LDI cycle interrupted by reset never writes
  assign we             = we_q && a_reset_l;
  assign result_o       = result_q;
  assign result_valid_o = result_vld_q;
  assign err_o          = err_q;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    data_in_d    = data_in_q;
    mux_sel_d    = mux_sel_q;
    seg_reg_d    = seg_reg_q;
    adr_a_d      = adr_a_q;
    adr_b_d      = adr_b_q;
    op_d         = op_q;
    we_d         = 1'b0;
    result_d     = result_q;
    result_vld_d = 1'b0;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid_i && instr_ready_o) begin
          instr_d = instr_i;
          state_d = ST_ISSUE;
          // Load the controls that become visible during ISSUE
          if (dec_ldi) begin
            data_in_d = dec_imm;
            mux_sel_d = IMM_SEL;
            seg_reg_d = dec_dest;
            we_d      = 1'b1;
          end else if (dec_alu) begin
            adr_a_d   = dec_adr_a;
            adr_b_d   = dec_adr_b;
            op_d      = dec_op;
            seg_reg_d = dec_dest;
          end else if (dec_rd) begin
            adr_a_d   = dec_adr_a;
            op_d      = OP_PASS_A;
          end
        end
      end

      ST_ISSUE: begin
        if (dec_alu || dec_rd) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // valid_o takes priority over an expiring timeout
        if (valid_o) begin
          if (dec_alu) begin
            state_d   = ST_WB;
            mux_sel_d = ALU_SEL;
            seg_reg_d = dec_dest;
            we_d      = 1'b1;
          end else begin
            result_d     = data_o;
            result_vld_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!a_reset_l) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      cnt_q        <= '0;
      data_in_q    <= '0;
      mux_sel_q    <= '0;
      seg_reg_q    <= '0;
      adr_a_q      <= '0;
      adr_b_q      <= '0;
      op_q         <= '0;
      we_q         <= 1'b0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      data_in_q    <= data_in_d;
      mux_sel_q    <= mux_sel_d;
      seg_reg_q    <= seg_reg_d;
      adr_a_q      <= adr_a_d;
      adr_b_q      <= adr_b_d;
      op_q         <= op_d;
      we_q         <= we_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      err_q        <= err_d;
    end
  end

endmodule
